meteor_pool: RTL

Parametrised pool of falling meteorites for the game playfield. It tracks position, velocity, hit points and lifecycle state for OBJ_NUM objects, and tests collisions against BULLET_NUM ammo points once per frame. Destroyed or escaped objects respawn at a supplied random column after a respawn delay. It sits between the random-number/spawn logic and the sprite renderer, and feeds hit and score signals to the game-state controller.

---
 rtl/meteor_pkg.sv | 60 ++++++
 rtl/meteor_slot.sv | 112 +++++++++++
 rtl/meteor_pool.sv | 133 +++++++++++++
 3 files changed

// File: rtl/meteor_pkg.sv
// Shared types, screen geometry and small helpers for the meteorite pool.
package meteor_pkg;

    localparam int unsigned OBJ_SIZE_PX    = 30;
    localparam int unsigned SCREEN_Y_LIMIT = 480;
    localparam int unsigned SCREEN_X_MIN   = 0;
    localparam int unsigned SCREEN_X_MAX   = 610;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned X_W     = 11;
    localparam int unsigned DX_W    = 4;
    localparam int unsigned DY_W    = 3;
    localparam int unsigned HP_W    = 2;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        ACTIVE  = 2'd1,
        EXPLODE = 2'd2
    } obj_state_t;

    // dx carries one extra bit so that bouncing a -4 speed yields +4
    typedef struct packed {
        logic signed [X_W-1:0]   x;
        logic [COORD_W-1:0]      y;
        logic signed [DX_W-1:0]  dx;
        logic [DY_W-1:0]         dy;
        logic [HP_W-1:0]         hp;
        obj_state_t              state;
        logic [CNT_W-1:0]        counter;
    } obj_t;

    function automatic logic signed [X_W-1:0] clamp_x(
        input logic signed [X_W-1:0] v,
        input logic signed [X_W-1:0] lo,
        input logic signed [X_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Point-in-square test; half-open on the far edges
    function automatic logic in_box(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] ox,
        input logic [COORD_W-1:0] oy,
        input int unsigned        size
    );
        logic [X_W-1:0] px_e, py_e, ox_e, oy_e;
        px_e = {1'b0, px};
        py_e = {1'b0, py};
        ox_e = {1'b0, ox};
        oy_e = {1'b0, oy};
        return (px_e >= ox_e) && (px_e < ox_e + X_W'(size)) &&
               (py_e >= oy_e) && (py_e < oy_e + X_W'(size));
    endfunction

endpackage

// File: rtl/meteor_slot.sv
// One meteorite slot: lifecycle FSM, frame counter, motion with wall bounce.
module meteor_slot
    import meteor_pkg::*;
#(
    parameter int unsigned RST_CNT        = 0,
    parameter int unsigned HP_INIT        = 2,
    parameter int unsigned RESPAWN_FRAMES = 32,
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter int unsigned Y_LIMIT        = SCREEN_Y_LIMIT,
    parameter int unsigned X_MIN          = SCREEN_X_MIN,
    parameter int unsigned X_MAX          = SCREEN_X_MAX
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               i_enable,
    input  logic               i_grant,
    input  logic               i_hit,
    input  logic [COORD_W-1:0] i_spawn_x,
    input  logic [2:0]         i_spawn_dx,
    input  logic [1:0]         i_spawn_dy,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [HP_W-1:0]    o_hp,
    output obj_state_t         o_state,
    output logic               o_eligible_c,
    output logic               o_kill_c,
    output logic               o_escape_c
);

    localparam logic signed [X_W-1:0] X_MIN_S = X_W'(X_MIN);
    localparam logic signed [X_W-1:0] X_MAX_S = X_W'(X_MAX);

    obj_t                   r_obj;
    obj_t                   w_next;
    logic signed [X_W-1:0]  w_x_sum;
    logic signed [X_W-1:0]  w_x_clamped;

    assign w_x_sum     = r_obj.x + X_W'(r_obj.dx);
    assign w_x_clamped = clamp_x(w_x_sum, X_MIN_S, X_MAX_S);

    // Next-state: a kill beats an escape; escaping skips motion for that frame
    always_comb begin
        w_next     = r_obj;
        o_kill_c   = 1'b0;
        o_escape_c = 1'b0;
        if (i_enable) begin
            case (r_obj.state)
                WAIT: begin
                    if (r_obj.counter != '0) begin
                        w_next.counter = r_obj.counter - CNT_W'(1);
                    end else if (i_grant) begin
                        w_next.state = ACTIVE;
                        w_next.x     = clamp_x($signed({1'b0, i_spawn_x}), X_MIN_S, X_MAX_S);
                        w_next.y     = '0;
                        w_next.hp    = HP_W'(HP_INIT);
                        w_next.dx    = DX_W'($signed(i_spawn_dx));
                        w_next.dy    = DY_W'(i_spawn_dy) + DY_W'(1);
                    end
                end
                ACTIVE: begin
                    if (i_hit && (r_obj.hp <= HP_W'(1))) begin
                        w_next.state   = EXPLODE;
                        w_next.hp      = '0;
                        w_next.counter = CNT_W'(EXPLODE_FRAMES - 1);
                        o_kill_c       = 1'b1;
                    end else if (r_obj.y > COORD_W'(Y_LIMIT)) begin
                        w_next.state   = WAIT;
                        w_next.counter = CNT_W'(RESPAWN_FRAMES);
                        o_escape_c     = 1'b1;
                    end else begin
                        if (i_hit) begin
                            w_next.hp = r_obj.hp - HP_W'(1);
                        end
                        w_next.y = r_obj.y + COORD_W'(r_obj.dy);
                        w_next.x = w_x_clamped;
                        if (w_x_clamped != w_x_sum) begin
                            w_next.dx = -r_obj.dx;
                        end
                    end
                end
                EXPLODE: begin
                    if (r_obj.counter == '0) begin
                        w_next.state   = WAIT;
                        w_next.counter = CNT_W'(RESPAWN_FRAMES);
                    end else begin
                        w_next.counter = r_obj.counter - CNT_W'(1);
                    end
                end
                default: begin
                    w_next.state   = WAIT;
                    w_next.counter = CNT_W'(RESPAWN_FRAMES);
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_obj <= '{x: '0, y: '0, dx: '0, dy: '0, hp: '0,
                       state: WAIT, counter: CNT_W'(RST_CNT)};
        end else begin
            r_obj <= w_next;
        end
    end

    assign o_x          = r_obj.x[COORD_W-1:0];
    assign o_y          = r_obj.y;
    assign o_hp         = r_obj.hp;
    assign o_state      = r_obj.state;
    assign o_eligible_c = (r_obj.state == WAIT) && (r_obj.counter == '0);

endmodule

// File: rtl/meteor_pool.sv
// Pool of meteorite slots with spawn arbitration, bullet collision and game pulses.
module meteor_pool
    import meteor_pkg::*;
#(
    parameter int unsigned OBJ_NUM        = 4,
    parameter int unsigned BULLET_NUM     = 2,
    parameter int unsigned OBJ_SIZE       = OBJ_SIZE_PX,
    parameter int unsigned HP_INIT        = 2,
    parameter int unsigned RESPAWN_FRAMES = 32,
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter int unsigned Y_LIMIT        = SCREEN_Y_LIMIT,
    parameter int unsigned X_MIN          = SCREEN_X_MIN,
    parameter int unsigned X_MAX          = SCREEN_X_MAX
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic                  i_enable,
    input  logic [COORD_W-1:0]    i_bullet_x [BULLET_NUM],
    input  logic [COORD_W-1:0]    i_bullet_y [BULLET_NUM],
    input  logic [BULLET_NUM-1:0] i_bullet_valid,
    input  logic [COORD_W-1:0]    i_spawn_x,
    input  logic [2:0]            i_spawn_dx,
    input  logic [1:0]            i_spawn_dy,
    output logic [COORD_W-1:0]    o_obj_x [OBJ_NUM],
    output logic [COORD_W-1:0]    o_obj_y [OBJ_NUM],
    output logic [1:0]            o_obj_state [OBJ_NUM],
    output logic [HP_W-1:0]       o_obj_hp [OBJ_NUM],
    output logic [BULLET_NUM-1:0] o_bullet_hit,
    output logic                  o_escaped,
    output logic [15:0]           o_destroyed_count
);

    logic [COORD_W-1:0]    w_x [OBJ_NUM];
    logic [COORD_W-1:0]    w_y [OBJ_NUM];
    obj_state_t            w_state [OBJ_NUM];
    logic [OBJ_NUM-1:0]    w_eligible;
    logic [OBJ_NUM-1:0]    w_grant;
    logic [OBJ_NUM-1:0]    w_kill;
    logic [OBJ_NUM-1:0]    w_escape;
    logic [OBJ_NUM-1:0]    w_slot_hit;
    logic [BULLET_NUM-1:0] w_bullet_hit_c;
    logic [16:0]           w_count_sum;
    logic [15:0]           w_count_next;

    logic [BULLET_NUM-1:0] r_bullet_hit;
    logic                  r_escaped;
    logic [15:0]           r_destroyed_count;

    for (genvar g = 0; g < OBJ_NUM; g++) begin : g_slot
        meteor_slot #(
            .RST_CNT        (g),
            .HP_INIT        (HP_INIT),
            .RESPAWN_FRAMES (RESPAWN_FRAMES),
            .EXPLODE_FRAMES (EXPLODE_FRAMES),
            .Y_LIMIT        (Y_LIMIT),
            .X_MIN          (X_MIN),
            .X_MAX          (X_MAX)
        ) u_slot (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .i_enable     (i_enable),
            .i_grant      (w_grant[g]),
            .i_hit        (w_slot_hit[g]),
            .i_spawn_x    (i_spawn_x),
            .i_spawn_dx   (i_spawn_dx),
            .i_spawn_dy   (i_spawn_dy),
            .o_x          (w_x[g]),
            .o_y          (w_y[g]),
            .o_hp         (o_obj_hp[g]),
            .o_state      (w_state[g]),
            .o_eligible_c (w_eligible[g]),
            .o_kill_c     (w_kill[g]),
            .o_escape_c   (w_escape[g])
        );

        assign o_obj_x[g]     = w_x[g];
        assign o_obj_y[g]     = w_y[g];
        assign o_obj_state[g] = 2'(w_state[g]);
    end

    // Lowest-index waiting slot with an expired counter gets the spawn
    always_comb begin
        w_grant = '0;
        for (int o = 0; o < OBJ_NUM; o++) begin
            if (w_eligible[o] && (w_grant == '0)) begin
                w_grant[o] = 1'b1;
            end
        end
    end

    // Each bullet damages only the first active slot it lands in
    always_comb begin
        w_slot_hit     = '0;
        w_bullet_hit_c = '0;
        for (int b = 0; b < BULLET_NUM; b++) begin
            for (int o = 0; o < OBJ_NUM; o++) begin
                if (i_bullet_valid[b] && !w_bullet_hit_c[b] && (w_state[o] == ACTIVE) &&
                    in_box(i_bullet_x[b], i_bullet_y[b], w_x[o], w_y[o], OBJ_SIZE)) begin
                    w_slot_hit[o]     = 1'b1;
                    w_bullet_hit_c[b] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_count_sum = {1'b0, r_destroyed_count};
        for (int o = 0; o < OBJ_NUM; o++) begin
            w_count_sum = w_count_sum + 17'(w_kill[o]);
        end
        w_count_next = (w_count_sum > 17'h0FFFF) ? 16'hFFFF : w_count_sum[15:0];
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_bullet_hit      <= '0;
            r_escaped         <= 1'b0;
            r_destroyed_count <= '0;
        end else if (i_enable) begin
            r_bullet_hit      <= w_bullet_hit_c;
            r_escaped         <= |w_escape;
            r_destroyed_count <= w_count_next;
        end else begin
            r_bullet_hit <= '0;
            r_escaped    <= 1'b0;
        end
    end

    assign o_bullet_hit      = r_bullet_hit;
    assign o_escaped         = r_escaped;
    assign o_destroyed_count = r_destroyed_count;

endmodule
